// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - single-entry reservation station with operand snoop and commit arbitration
module reservation_station #(
    parameter logic [3:0] RS_ID      = 4'd1,
    parameter int         DATA_WIDTH = 96,
    parameter int         DST_WIDTH  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [3:0]            iIssueRsID,
    input  logic [3:0]            iIssueSrc0Rs,
    input  logic [3:0]            iIssueSrc1Rs,
    input  logic [DATA_WIDTH-1:0] iIssueSrc0Data,
    input  logic [DATA_WIDTH-1:0] iIssueSrc1Data,
    input  logic [3:0]            iIssueScale,
    input  logic [2:0]            iIssueWE,
    input  logic [DST_WIDTH-1:0]  iIssueDst,
    input  logic [3:0]            iModCommitRsID,
    input  logic [DATA_WIDTH-1:0] iModCommitData,
    output logic                  oBusy,
    output logic                  oExecValid,
    input  logic                  iExecReady,
    output logic [DATA_WIDTH-1:0] oExecSrc0,
    output logic [DATA_WIDTH-1:0] oExecSrc1,
    output logic [3:0]            oExecScale,
    input  logic                  iResultValid,
    input  logic [DATA_WIDTH-1:0] iResult,
    output logic                  oCommitRequest,
    input  logic                  iCommitGrant,
    output logic [3:0]            oCommitRsID,
    output logic [2:0]            oCommitWE,
    output logic [DST_WIDTH-1:0]  oCommitDst,
    output logic [DATA_WIDTH-1:0] oCommitData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OPS,
        S_EXEC_REQ,
        S_EXECUTING,
        S_COMMIT_REQ
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] src0_q, src0_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [3:0]            src0_rs_q, src0_rs_d;
    logic [3:0]            src1_rs_q, src1_rs_d;
    logic                  src0_rdy_q, src0_rdy_d;
    logic                  src1_rdy_q, src1_rdy_d;
    logic [3:0]            scale_q, scale_d;
    logic [2:0]            we_q, we_d;
    logic [DST_WIDTH-1:0]  dst_q, dst_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic bus_live;
    logic issue_hit0, issue_hit1;
    logic wait_hit0, wait_hit1;
    logic granted;

    // Our own id on the bus is never a valid producer for this entry.
    assign bus_live   = (iModCommitRsID != 4'd0) && (iModCommitRsID != RS_ID);
    assign issue_hit0 = bus_live && (iModCommitRsID == iIssueSrc0Rs);
    assign issue_hit1 = bus_live && (iModCommitRsID == iIssueSrc1Rs);
    assign wait_hit0  = bus_live && (iModCommitRsID == src0_rs_q);
    assign wait_hit1  = bus_live && (iModCommitRsID == src1_rs_q);

    always_comb begin
        state_d    = state_q;
        src0_d     = src0_q;
        src1_d     = src1_q;
        src0_rs_d  = src0_rs_q;
        src1_rs_d  = src1_rs_q;
        src0_rdy_d = src0_rdy_q;
        src1_rdy_d = src1_rdy_q;
        scale_d    = scale_q;
        we_d       = we_q;
        dst_d      = dst_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (iIssueRsID == RS_ID) begin
                    scale_d    = iIssueScale;
                    we_d       = iIssueWE;
                    dst_d      = iIssueDst;
                    src0_rs_d  = iIssueSrc0Rs;
                    src1_rs_d  = iIssueSrc1Rs;
                    src0_rdy_d = (iIssueSrc0Rs == 4'd0) || issue_hit0;
                    src1_rdy_d = (iIssueSrc1Rs == 4'd0) || issue_hit1;
                    src0_d     = issue_hit0 ? iModCommitData : iIssueSrc0Data;
                    src1_d     = issue_hit1 ? iModCommitData : iIssueSrc1Data;
                    state_d    = (src0_rdy_d && src1_rdy_d) ? S_EXEC_REQ : S_WAIT_OPS;
                end
            end
            S_WAIT_OPS: begin
                // Readiness is acted on from the registered flags, one cycle after capture.
                if (src0_rdy_q && src1_rdy_q) begin
                    state_d = S_EXEC_REQ;
                end else begin
                    if (!src0_rdy_q && wait_hit0) begin
                        src0_d     = iModCommitData;
                        src0_rdy_d = 1'b1;
                    end
                    if (!src1_rdy_q && wait_hit1) begin
                        src1_d     = iModCommitData;
                        src1_rdy_d = 1'b1;
                    end
                end
            end
            S_EXEC_REQ: begin
                if (iExecReady) state_d = S_EXECUTING;
            end
            S_EXECUTING: begin
                if (iResultValid) begin
                    result_d = iResult;
                    state_d  = S_COMMIT_REQ;
                end
            end
            S_COMMIT_REQ: begin
                if (iCommitGrant) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            src0_q     <= '0;
            src1_q     <= '0;
            src0_rs_q  <= '0;
            src1_rs_q  <= '0;
            src0_rdy_q <= 1'b0;
            src1_rdy_q <= 1'b0;
            scale_q    <= '0;
            we_q       <= '0;
            dst_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            src0_q     <= src0_d;
            src1_q     <= src1_d;
            src0_rs_q  <= src0_rs_d;
            src1_rs_q  <= src1_rs_d;
            src0_rdy_q <= src0_rdy_d;
            src1_rdy_q <= src1_rdy_d;
            scale_q    <= scale_d;
            we_q       <= we_d;
            dst_q      <= dst_d;
            result_q   <= result_d;
        end
    end

    assign granted        = (state_q == S_COMMIT_REQ) && iCommitGrant;
    assign oBusy          = (state_q != S_IDLE);
    assign oExecValid     = (state_q == S_EXEC_REQ);
    assign oExecSrc0      = src0_q;
    assign oExecSrc1      = src1_q;
    assign oExecScale     = scale_q;
    assign oCommitRequest = (state_q == S_COMMIT_REQ);
    assign oCommitRsID    = granted ? RS_ID    : 4'd0;
    assign oCommitWE      = granted ? we_q     : 3'd0;
    assign oCommitDst     = granted ? dst_q    : '0;
    assign oCommitData    = granted ? result_q : '0;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and randomized bench for reservation_station
module tb_reservation_station;

    localparam logic [3:0] RS_ID = 4'd1;
    localparam int DW = 96;
    localparam int AW = 8;

    logic          Clock, Reset;
    logic [3:0]    iIssueRsID, iIssueSrc0Rs, iIssueSrc1Rs, iIssueScale;
    logic [DW-1:0] iIssueSrc0Data, iIssueSrc1Data, iModCommitData, iResult;
    logic [2:0]    iIssueWE;
    logic [AW-1:0] iIssueDst;
    logic [3:0]    iModCommitRsID;
    logic          oBusy, oExecValid, iExecReady, iResultValid, oCommitRequest, iCommitGrant;
    logic [DW-1:0] oExecSrc0, oExecSrc1, oCommitData;
    logic [3:0]    oExecScale, oCommitRsID;
    logic [2:0]    oCommitWE;
    logic [AW-1:0] oCommitDst;

    reservation_station #(.RS_ID(RS_ID), .DATA_WIDTH(DW), .DST_WIDTH(AW)) dut (
        .Clock(Clock), .Reset(Reset),
        .iIssueRsID(iIssueRsID), .iIssueSrc0Rs(iIssueSrc0Rs), .iIssueSrc1Rs(iIssueSrc1Rs),
        .iIssueSrc0Data(iIssueSrc0Data), .iIssueSrc1Data(iIssueSrc1Data),
        .iIssueScale(iIssueScale), .iIssueWE(iIssueWE), .iIssueDst(iIssueDst),
        .iModCommitRsID(iModCommitRsID), .iModCommitData(iModCommitData),
        .oBusy(oBusy), .oExecValid(oExecValid), .iExecReady(iExecReady),
        .oExecSrc0(oExecSrc0), .oExecSrc1(oExecSrc1), .oExecScale(oExecScale),
        .iResultValid(iResultValid), .iResult(iResult),
        .oCommitRequest(oCommitRequest), .iCommitGrant(iCommitGrant),
        .oCommitRsID(oCommitRsID), .oCommitWE(oCommitWE), .oCommitDst(oCommitDst),
        .oCommitData(oCommitData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_commits = 0;
    int m_commits   = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entry contents plus which phase of its life the entry is in.
    bit            m_occ, m_offer, m_run, m_done, m_have0, m_have1;
    logic [3:0]    m_dep0, m_dep1, m_scale;
    logic [2:0]    m_we;
    logic [AW-1:0] m_dst;
    logic [DW-1:0] m_v0, m_v1, m_res;

    function automatic bit fwd(input logic [3:0] dep);
        return (iModCommitRsID != 4'd0) && (iModCommitRsID == dep) && (iModCommitRsID != RS_ID);
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            m_occ = 0; m_offer = 0; m_run = 0; m_done = 0; m_have0 = 0; m_have1 = 0;
        end else if (!m_occ) begin
            if (iIssueRsID == RS_ID) begin
                m_occ = 1;
                m_dep0 = iIssueSrc0Rs; m_dep1 = iIssueSrc1Rs;
                m_scale = iIssueScale; m_we = iIssueWE; m_dst = iIssueDst;
                m_have0 = (m_dep0 == 0) || fwd(m_dep0);
                m_have1 = (m_dep1 == 0) || fwd(m_dep1);
                m_v0 = fwd(m_dep0) ? iModCommitData : iIssueSrc0Data;
                m_v1 = fwd(m_dep1) ? iModCommitData : iIssueSrc1Data;
                m_offer = m_have0 && m_have1;
            end
        end else if (m_offer) begin
            if (iExecReady) begin m_offer = 0; m_run = 1; end
        end else if (m_run) begin
            if (iResultValid) begin m_run = 0; m_done = 1; m_res = iResult; end
        end else if (m_done) begin
            if (iCommitGrant) begin m_done = 0; m_occ = 0; m_commits++; end
        end else if (m_have0 && m_have1) begin
            m_offer = 1;
        end else begin
            if (!m_have0 && fwd(m_dep0)) begin m_have0 = 1; m_v0 = iModCommitData; end
            if (!m_have1 && fwd(m_dep1)) begin m_have1 = 1; m_v1 = iModCommitData; end
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            bit g;
            g = m_done && iCommitGrant;
            check("busy", oBusy, m_occ);
            check("exec_valid", oExecValid, m_offer);
            if (m_offer) begin
                check("exec_src0", oExecSrc0, m_v0);
                check("exec_src1", oExecSrc1, m_v1);
                check("exec_scale", oExecScale, m_scale);
            end
            check("commit_req", oCommitRequest, m_done);
            check("commit_rsid", oCommitRsID, g ? RS_ID : 4'd0);
            check("commit_we", oCommitWE, g ? m_we : 3'd0);
            check("commit_dst", oCommitDst, g ? m_dst : '0);
            check("commit_data", oCommitData, g ? m_res : '0);
            if (oCommitRsID == RS_ID) dut_commits++;
        end
    end

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] id, input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [3:0] sc,
                         input logic [2:0] we, input logic [AW-1:0] dst);
        iIssueRsID = id; iIssueSrc0Rs = rs0; iIssueSrc1Rs = rs1;
        iIssueSrc0Data = d0; iIssueSrc1Data = d1;
        iIssueScale = sc; iIssueWE = we; iIssueDst = dst;
    endtask

    // Entered during an EXEC_REQ cycle; completes execution and commits after gdelay ungranted cycles.
    task automatic drain(input logic [DW-1:0] r, input int gdelay);
        iExecReady = 1; step; iExecReady = 0;
        iResultValid = 1; iResult = r; step; iResultValid = 0;
        check("lit_commit_req", oCommitRequest, 1'b1);
        for (int i = 0; i < gdelay; i++) begin
            check("lit_no_grant_rsid", oCommitRsID, 4'd0);
            step;
            check("lit_req_held", oCommitRequest, 1'b1);
        end
        iCommitGrant = 1; #1;
        check("lit_commit_rsid", oCommitRsID, 4'd1);
        check("lit_commit_data", oCommitData, r);
        step; iCommitGrant = 0;
        check("lit_busy_after_commit", oBusy, 1'b0);
    endtask

    logic [DW-1:0] ra, rb, rd;

    initial begin
        issue(0, 0, 0, '0, '0, 0, 0, 0);
        iModCommitRsID = 0; iModCommitData = '0; iExecReady = 0;
        iResultValid = 0; iResult = '0; iCommitGrant = 0;
        Reset = 1;
        step; chk_en = 1; step;
        Reset = 0;
        check("lit_reset_busy", oBusy, 1'b0);
        check("lit_reset_exec", oExecValid, 1'b0);
        check("lit_reset_src0", oExecSrc0, '0);

        // T1: both operands ready at issue
        ra = {32'h0, 32'h0, 32'h1}; rb = {32'h0, 32'h0, 32'h2};
        issue(1, 0, 0, ra, rb, 4'd5, 3'b101, 8'h22); step; iIssueRsID = 0;
        check("lit_t1_exec", oExecValid, 1'b1);
        check("lit_t1_src0", oExecSrc0, ra);
        check("lit_t1_src1", oExecSrc1, rb);
        check("lit_t1_scale", oExecScale, 4'd5);
        drain({32'hA, 32'hB, 32'hC}, 0);

        // T2: src0 forwarded three cycles after issue
        rd = {32'hDDDD_0001, 32'hDDDD_0002, 32'hDDDD_0003};
        issue(1, 2, 0, {3{32'h1111_1111}}, {3{32'h2222_2222}}, 4'd3, 3'b111, 8'h40);
        step; iIssueRsID = 0; step; step;
        iModCommitRsID = 2; iModCommitData = rd; step; iModCommitRsID = 0;
        check("lit_t2_no_early_exec", oExecValid, 1'b0);
        step;
        check("lit_t2_exec", oExecValid, 1'b1);
        check("lit_t2_src0", oExecSrc0, rd);
        check("lit_t2_src1", oExecSrc1, {3{32'h2222_2222}});
        drain({3{32'h5A5A_5A5A}}, 1);

        // T3: both sources bypassed from the same broadcast at issue
        rd = {32'h3333_0000, 32'h0, 32'h3};
        iModCommitRsID = 3; iModCommitData = rd;
        issue(1, 3, 3, '0, '1, 4'd1, 3'b010, 8'h03); step;
        iIssueRsID = 0; iModCommitRsID = 0;
        check("lit_t3_exec", oExecValid, 1'b1);
        check("lit_t3_src0", oExecSrc0, rd);
        check("lit_t3_src1", oExecSrc1, rd);
        drain({3{32'h0000_0333}}, 0);

        // T4: FU stall then arbiter stall
        ra = {32'h4, 32'h44, 32'h444};
        issue(1, 0, 0, ra, ~ra, 4'd9, 3'b001, 8'h44); step; iIssueRsID = 0;
        for (int i = 0; i < 5; i++) begin
            check("lit_t4_exec_held", oExecValid, 1'b1);
            check("lit_t4_src0_stable", oExecSrc0, ra);
            step;
        end
        drain({3{32'h4444_4444}}, 4);

        // T5: reset while executing abandons the entry
        issue(1, 0, 0, ra, rb, 4'd2, 3'b111, 8'h55); step; iIssueRsID = 0;
        iExecReady = 1; step; iExecReady = 0;
        Reset = 1; step; Reset = 0;
        check("lit_t5_busy", oBusy, 1'b0);
        check("lit_t5_req", oCommitRequest, 1'b0);
        check("lit_t5_src0", oExecSrc0, '0);
        iResultValid = 1; iResult = '1; step; iResultValid = 0;
        check("lit_t5_no_req", oCommitRequest, 1'b0);
        iCommitGrant = 1; #1;
        check("lit_t5_no_commit", oCommitRsID, 4'd0);
        step; iCommitGrant = 0;

        // T6: foreign issue and issue-while-busy are ignored
        issue(5, 0, 0, ra, rb, 4'd1, 3'b111, 8'h66); step; iIssueRsID = 0;
        check("lit_t6_foreign", oBusy, 1'b0);
        rb = {3{32'h6666_0006}};
        issue(1, 4, 0, ra, rb, 4'd6, 3'b100, 8'h66); step;
        check("lit_t6_busy", oBusy, 1'b1);
        issue(1, 0, 0, '1, '1, 4'd7, 3'b011, 8'h77); step; iIssueRsID = 0;
        check("lit_t6_still_wait", oExecValid, 1'b0);
        iModCommitRsID = 1; iModCommitData = '1; step;
        rd = {3{32'hD6D6_D6D6}};
        iModCommitRsID = 4; iModCommitData = rd; step; iModCommitRsID = 0; step;
        check("lit_t6_exec", oExecValid, 1'b1);
        check("lit_t6_src0", oExecSrc0, rd);
        check("lit_t6_src1", oExecSrc1, rb);
        check("lit_t6_scale", oExecScale, 4'd6);
        drain({3{32'h0606_0606}}, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int v;
            v = $urandom_range(0, 3);
            iIssueRsID = (v == 0) ? 4'd0 : (v == 3) ? 4'd5 : 4'd1;
            v = $urandom_range(0, 4); iIssueSrc0Rs = (v < 2) ? 4'd0 : 4'(v);
            v = $urandom_range(0, 4); iIssueSrc1Rs = (v < 2) ? 4'd0 : 4'(v);
            iIssueSrc0Data = {$urandom, $urandom, $urandom};
            iIssueSrc1Data = {$urandom, $urandom, $urandom};
            iIssueScale = 4'($urandom); iIssueWE = 3'($urandom); iIssueDst = 8'($urandom);
            iModCommitRsID = 4'($urandom_range(0, 5));
            iModCommitData = {$urandom, $urandom, $urandom};
            iExecReady = 1'($urandom); iResultValid = 1'($urandom);
            iResult = {$urandom, $urandom, $urandom};
            iCommitGrant = 1'($urandom);
            Reset = ($urandom_range(0, 255) == 0);
            step;
        end
        Reset = 0; iIssueRsID = 0; iModCommitRsID = 0;
        step;
        check("commit_count", dut_commits, m_commits);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
